// File: rtl/wb_arbiter.sv
// wb_arbiter: drives the single regfile write port from the main pipe and the
// multdiv unit. Multdiv results that lose to the pipe wait in a small FIFO; a
// starvation counter forces a one-cycle pipe stall so the FIFO head drains.
// Optional feature: define WB_PENDMASK_EN to add the registered pend_mask output.
module wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clock,
    input  logic                          ctrl_reset,
    input  logic                          pipe_valid,
    input  logic [4:0]                    pipe_reg,
    input  logic [31:0]                   pipe_data,
    input  logic                          md_valid,
    input  logic [4:0]                    md_reg,
    input  logic [31:0]                   md_data,
    output logic                          md_ready,
    output logic                          pipe_stall,
    output logic                          ctrl_writeEnable,
    output logic [4:0]                    ctrl_writeReg,
    output logic [31:0]                   data_writeReg,
    output logic [$clog2(FIFO_DEPTH):0]   pend_count
`ifdef WB_PENDMASK_EN
    ,
    output logic [31:0]                   pend_mask
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_DIRECT
    } src_t;

    logic [4:0]    fifo_reg  [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [SW-1:0] starve_cnt;

    logic fifo_empty;
    logic md_accept;
    logic pipe_take;
    logic push;
    logic pop;
    logic starve_hit;
    src_t src;

    // Handshake, winner selection and FIFO push/pop decisions
    always_comb begin
        md_ready   = !ctrl_reset && (pend_count < CW'(FIFO_DEPTH));
        fifo_empty = (pend_count == '0);
        md_accept  = md_valid && md_ready;
        // pipe input is ignored while stalled so the FIFO head wins
        pipe_take  = pipe_valid && (pipe_reg != '0) && !pipe_stall;
        src        = SRC_NONE;
        if (pipe_take)
            src = SRC_PIPE;
        else if (!fifo_empty)
            src = SRC_FIFO;
        else if (md_accept && (md_reg != '0))
            src = SRC_DIRECT;
        push       = md_accept && (md_reg != '0) && (src != SRC_DIRECT);
        pop        = (src == SRC_FIFO);
        starve_hit = !fifo_empty && (src == SRC_PIPE) &&
                     (starve_cnt == SW'(STARVE_LIMIT - 1));
    end

    // FIFO storage; contents are only meaningful while counted, so no reset
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= md_reg;
            fifo_data[wr_ptr] <= md_data;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            pend_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                pend_count <= pend_count + CW'(1);
            else if (pop && !push)
                pend_count <= pend_count - CW'(1);
        end
    end

    // Starvation counter and the one-cycle pipe_stall pulse
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= starve_hit;
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (src == SRC_PIPE)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Registered regfile write port; address/data hold when idle
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else begin
            unique case (src)
                SRC_PIPE: begin
                    ctrl_writeEnable <= 1'b1;
                    ctrl_writeReg    <= pipe_reg;
                    data_writeReg    <= pipe_data;
                end
                SRC_FIFO: begin
                    ctrl_writeEnable <= 1'b1;
                    ctrl_writeReg    <= fifo_reg[rd_ptr];
                    data_writeReg    <= fifo_data[rd_ptr];
                end
                SRC_DIRECT: begin
                    ctrl_writeEnable <= 1'b1;
                    ctrl_writeReg    <= md_reg;
                    data_writeReg    <= md_data;
                end
                default: begin
                    ctrl_writeEnable <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_PENDMASK_EN
    logic [FIFO_DEPTH-1:0] slot_vld;
    logic [31:0]           mask_d;

    // Per-slot occupancy flags used to build the pending-register mask
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            slot_vld <= '0;
        end else begin
            if (pop)
                slot_vld[rd_ptr] <= 1'b0;
            if (push)
                slot_vld[wr_ptr] <= 1'b1;
        end
    end

    // Next mask: post-update FIFO contents plus the multdiv result being written
    always_comb begin
        mask_d = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (push && (PW'(i) == wr_ptr))
                mask_d[md_reg] = 1'b1;
            else if (slot_vld[i] && !(pop && (PW'(i) == rd_ptr)))
                mask_d[fifo_reg[i]] = 1'b1;
        end
        if (src == SRC_FIFO)
            mask_d[fifo_reg[rd_ptr]] = 1'b1;
        if (src == SRC_DIRECT)
            mask_d[md_reg] = 1'b1;
        mask_d[0] = 1'b0;
    end

    // Registered pending-register mask for the hazard unit
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            pend_mask <= '0;
        else
            pend_mask <= mask_d;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table-driven checks of wb_arbiter plus a
// hand-written mid-stream reset sequence.
module tb_wb_arbiter;

    logic        clock;
    logic        ctrl_reset;
    logic        pipe_valid;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready;
    logic        pipe_stall;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [1:0]  pend_count;
`ifdef WB_PENDMASK_EN
    logic [31:0] pend_mask;
`endif

    int total;
    int bad;

    wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .pipe_valid       (pipe_valid),
        .pipe_reg         (pipe_reg),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .pipe_stall       (pipe_stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pend_count       (pend_count)
`ifdef WB_PENDMASK_EN
        ,
        .pend_mask        (pend_mask)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        pv;
        logic [4:0]  pr;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] mdat;
        logic        rdy;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [1:0]  cnt;
        logic        stall;
    } vec_t;

    localparam int NV = 26;
    vec_t tv [NV];

    function automatic vec_t mk(logic pv, logic [4:0] pr, logic [31:0] pd,
                                logic mv, logic [4:0] mr, logic [31:0] mdat,
                                logic rdy, logic we, logic [4:0] wr,
                                logic [31:0] wd, logic [1:0] cnt, logic stall);
        vec_t v;
        v.pv = pv; v.pr = pr; v.pd = pd;
        v.mv = mv; v.mr = mr; v.mdat = mdat;
        v.rdy = rdy; v.we = we; v.wr = wr; v.wd = wd; v.cnt = cnt; v.stall = stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] mdat);
        pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
        md_valid = mv; md_reg = mr; md_data = mdat;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //            pv pr  pd           mv mr  md            rdy we wr  wd           cnt st
        tv[0]  = mk(0, 0,  0,           0, 0,  0,           1, 0, 0,  0,           0, 0); // idle
        tv[1]  = mk(0, 0,  0,           1, 7,  32'hDEADBEEF,1, 1, 7,  32'hDEADBEEF,0, 0); // direct
        tv[2]  = mk(0, 0,  0,           0, 0,  0,           1, 0, 7,  32'hDEADBEEF,0, 0); // hold
        tv[3]  = mk(1, 3,  1,           1, 5,  2,           1, 1, 3,  1,           1, 0); // collision
        tv[4]  = mk(0, 0,  0,           0, 0,  0,           1, 1, 5,  2,           0, 0); // drain r5
        tv[5]  = mk(0, 0,  0,           0, 0,  0,           1, 0, 5,  2,           0, 0);
        tv[6]  = mk(1, 20, 32'h100,     1, 10, 32'h11,      1, 1, 20, 32'h100,     1, 0); // full
        tv[7]  = mk(1, 21, 32'h101,     1, 11, 32'h22,      1, 1, 21, 32'h101,     2, 0);
        tv[8]  = mk(1, 22, 32'h102,     1, 12, 32'h33,      0, 1, 22, 32'h102,     2, 0);
        tv[9]  = mk(1, 23, 32'h103,     1, 12, 32'h33,      0, 1, 23, 32'h103,     2, 0);
        tv[10] = mk(1, 24, 32'h104,     1, 12, 32'h33,      0, 1, 24, 32'h104,     2, 1);
        tv[11] = mk(1, 25, 32'h105,     1, 12, 32'h33,      0, 1, 10, 32'h11,      1, 0); // pipe ignored
        tv[12] = mk(1, 26, 32'h106,     1, 12, 32'h33,      1, 1, 26, 32'h106,     2, 0);
        tv[13] = mk(0, 0,  0,           0, 0,  0,           0, 1, 11, 32'h22,      1, 0);
        tv[14] = mk(0, 0,  0,           0, 0,  0,           1, 1, 12, 32'h33,      0, 0);
        tv[15] = mk(0, 0,  0,           0, 0,  0,           1, 0, 12, 32'h33,      0, 0);
        tv[16] = mk(1, 1,  32'hA1,      1, 9,  32'h99,      1, 1, 1,  32'hA1,      1, 0); // starvation
        tv[17] = mk(1, 2,  32'hA2,      0, 0,  0,           1, 1, 2,  32'hA2,      1, 0);
        tv[18] = mk(1, 3,  32'hA3,      0, 0,  0,           1, 1, 3,  32'hA3,      1, 0);
        tv[19] = mk(1, 4,  32'hA4,      0, 0,  0,           1, 1, 4,  32'hA4,      1, 0);
        tv[20] = mk(1, 5,  32'hA5,      0, 0,  0,           1, 1, 5,  32'hA5,      1, 1);
        tv[21] = mk(0, 0,  0,           0, 0,  0,           1, 1, 9,  32'h99,      0, 0);
        tv[22] = mk(1, 13, 32'hB1,      1, 9,  32'h909,     1, 1, 13, 32'hB1,      1, 0); // r0 cases
        tv[23] = mk(1, 0,  32'hBAD,     1, 0,  32'hBAD2,    1, 1, 9,  32'h909,     0, 0);
        tv[24] = mk(0, 0,  0,           1, 0,  32'h5,       1, 0, 9,  32'h909,     0, 0);
        tv[25] = mk(1, 0,  32'h77,      0, 0,  0,           1, 0, 9,  32'h909,     0, 0);

        ctrl_reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_we",    32'(ctrl_writeEnable), 0);
        chk("rst_reg",   32'(ctrl_writeReg),    0);
        chk("rst_data",  data_writeReg,         0);
        chk("rst_cnt",   32'(pend_count),       0);
        chk("rst_rdy",   32'(md_ready),         0);
        chk("rst_stall", 32'(pipe_stall),       0);
        @(negedge clock);
        ctrl_reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(tv[i].pv, tv[i].pr, tv[i].pd, tv[i].mv, tv[i].mr, tv[i].mdat);
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(md_ready), 32'(tv[i].rdy));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_we", i),    32'(ctrl_writeEnable), 32'(tv[i].we));
            chk($sformatf("v%0d_reg", i),   32'(ctrl_writeReg),    32'(tv[i].wr));
            chk($sformatf("v%0d_data", i),  data_writeReg,         tv[i].wd);
            chk($sformatf("v%0d_cnt", i),   32'(pend_count),       32'(tv[i].cnt));
            chk($sformatf("v%0d_stall", i), 32'(pipe_stall),       32'(tv[i].stall));
        end

        // mid-stream reset with two buffered results
        @(negedge clock);
        drive(1, 14, 32'hE1, 1, 15, 32'hF1);
        @(posedge clock);
        #1;
        chk("t1_cnt1", 32'(pend_count), 1);
        @(negedge clock);
        drive(1, 16, 32'hE2, 1, 17, 32'hF2);
        @(posedge clock);
        #1;
        chk("t1_cnt2", 32'(pend_count), 2);
        chk("t1_reg",  32'(ctrl_writeReg), 16);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        ctrl_reset = 1'b1;
        #1;
        chk("t1_we0",   32'(ctrl_writeEnable), 0);
        chk("t1_reg0",  32'(ctrl_writeReg),    0);
        chk("t1_data0", data_writeReg,         0);
        chk("t1_cnt0",  32'(pend_count),       0);
        chk("t1_rdy0",  32'(md_ready),         0);
        chk("t1_stl0",  32'(pipe_stall),       0);
        @(posedge clock);
        #1;
        chk("t1_hold_cnt", 32'(pend_count), 0);
        chk("t1_hold_rdy", 32'(md_ready),   0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        #1;
        chk("t1_rdy_up", 32'(md_ready),   1);
        chk("t1_cnt_up", 32'(pend_count), 0);
        @(posedge clock);
        #1;
        chk("t1_no_stale_we", 32'(ctrl_writeEnable), 0);
        chk("t1_no_stale_cnt", 32'(pend_count),      0);

        // direct path still works after reset
        @(negedge clock);
        drive(0, 0, 0, 1, 30, 32'h1234_5678);
        @(posedge clock);
        #1;
        chk("post_we",   32'(ctrl_writeEnable), 1);
        chk("post_reg",  32'(ctrl_writeReg),    30);
        chk("post_data", data_writeReg,         32'h1234_5678);
        chk("post_cnt",  32'(pend_count),       0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
